// File: rtl/vec_cache_evict_wb_ctrl.sv
// Evict write-back controller: buffers evict beats, issues them downstream under a
// line credit limit, releases evict data buffer entries and reports in-order completions.
module vec_cache_evict_wb_ctrl #(
    parameter int unsigned DATA_WIDTH      = 1024,
    parameter int unsigned ADDR_WIDTH      = 40,
    parameter int unsigned ROB_ID_WIDTH    = 6,
    parameter int unsigned DB_ID_WIDTH     = 6,
    parameter int unsigned TXN_ID_WIDTH    = 8,
    parameter int unsigned SB_WIDTH        = 8,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned BEATS_PER_LINE  = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 evict_in_vld,
    output logic                                 evict_in_rdy,
    input  logic [DATA_WIDTH-1:0]                evict_in_data,
    input  logic [ADDR_WIDTH-1:0]                evict_in_addr,
    input  logic                                 evict_in_last,
    input  logic [ROB_ID_WIDTH-1:0]              evict_in_rob_entry_id,
    input  logic [DB_ID_WIDTH-1:0]               evict_in_db_entry_id,
    input  logic [TXN_ID_WIDTH-1:0]              evict_in_txn_id,
    input  logic [SB_WIDTH-1:0]                  evict_in_sideband,
    output logic                                 ds_wr_vld,
    input  logic                                 ds_wr_rdy,
    output logic [DATA_WIDTH-1:0]                ds_wr_data,
    output logic [ADDR_WIDTH-1:0]                ds_wr_addr,
    output logic                                 ds_wr_last,
    output logic [TXN_ID_WIDTH-1:0]              ds_wr_txn_id,
    output logic [SB_WIDTH-1:0]                  ds_wr_sideband,
    input  logic                                 ds_bresp_vld,
    input  logic                                 ds_bresp_err,
    output logic                                 evdb_entry_release,
    output logic [DB_ID_WIDTH-3:0]               evdb_entry_release_idx,
    output logic                                 wb_done_vld,
    output logic [ROB_ID_WIDTH-1:0]              wb_done_rob_entry_id,
    output logic                                 wb_done_err,
    output logic [$clog2(MAX_OUTSTANDING):0]     outstanding_cnt,
    output logic                                 proto_err
);

    localparam int unsigned FPW  = $clog2(FIFO_DEPTH);
    localparam int unsigned FCW  = FPW + 1;
    localparam int unsigned TPW  = $clog2(MAX_OUTSTANDING);
    localparam int unsigned OCW  = TPW + 1;
    localparam int unsigned BCW  = (BEATS_PER_LINE > 1) ? $clog2(BEATS_PER_LINE) : 1;
    localparam int unsigned IDXW = DB_ID_WIDTH - 2;

    logic [DATA_WIDTH-1:0]   data_mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]   addr_mem [FIFO_DEPTH];
    logic                    last_mem [FIFO_DEPTH];
    logic [ROB_ID_WIDTH-1:0] rob_mem  [FIFO_DEPTH];
    logic [IDXW-1:0]         idx_mem  [FIFO_DEPTH];
    logic [TXN_ID_WIDTH-1:0] txn_mem  [FIFO_DEPTH];
    logic [SB_WIDTH-1:0]     sb_mem   [FIFO_DEPTH];

    logic [FPW-1:0]          wr_ptr;
    logic [FPW-1:0]          rd_ptr;
    logic [FCW-1:0]          fifo_cnt;
    logic                    full;
    logic                    empty;
    logic                    push;
    logic                    pop;

    logic [BCW-1:0]          beat_cnt;
    logic                    beat_at_end;
    logic                    line_done;
    logic                    beat_err;

    logic [ROB_ID_WIDTH-1:0] trk_mem [MAX_OUTSTANDING];
    logic [TPW-1:0]          trk_wr;
    logic [TPW-1:0]          trk_rd;
    logic                    trk_empty;
    logic                    trk_pop;
    logic                    bresp_unexp;

    logic                    unused_db_beat;

    assign unused_db_beat = ^evict_in_db_entry_id[1:0];

    assign full         = (fifo_cnt == FCW'(FIFO_DEPTH));
    assign empty        = (fifo_cnt == '0);
    assign evict_in_rdy = !full;
    assign push         = evict_in_vld && !full;
    assign pop          = ds_wr_vld && ds_wr_rdy;

    // A new line needs a free credit; a line already under way always proceeds.
    assign ds_wr_vld = !empty && ((beat_cnt != '0) || (outstanding_cnt < OCW'(MAX_OUTSTANDING)));

    assign ds_wr_data     = data_mem[rd_ptr];
    assign ds_wr_addr     = addr_mem[rd_ptr];
    assign ds_wr_last     = last_mem[rd_ptr];
    assign ds_wr_txn_id   = txn_mem[rd_ptr];
    assign ds_wr_sideband = sb_mem[rd_ptr];

    assign beat_at_end = (beat_cnt == BCW'(BEATS_PER_LINE - 1));
    assign line_done   = pop && ds_wr_last;
    assign beat_err    = pop && (ds_wr_last != beat_at_end);

    assign trk_empty   = (outstanding_cnt == '0);
    assign trk_pop     = ds_bresp_vld && !trk_empty;
    assign bresp_unexp = ds_bresp_vld && trk_empty;

    // Beat storage (payload only, no reset needed)
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= evict_in_data;
            addr_mem[wr_ptr] <= evict_in_addr;
            last_mem[wr_ptr] <= evict_in_last;
            rob_mem[wr_ptr]  <= evict_in_rob_entry_id;
            idx_mem[wr_ptr]  <= evict_in_db_entry_id[DB_ID_WIDTH-1:2];
            txn_mem[wr_ptr]  <= evict_in_txn_id;
            sb_mem[wr_ptr]   <= evict_in_sideband;
        end
    end

    // Response tracker storage: ROB ids of lines awaiting a write response
    always_ff @(posedge clk) begin
        if (line_done) begin
            trk_mem[trk_wr] <= rob_mem[rd_ptr];
        end
    end

    // Beat FIFO control
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + FPW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FPW'(1);
            end
            if (push && !pop) begin
                fifo_cnt <= fifo_cnt + FCW'(1);
            end else if (!push && pop) begin
                fifo_cnt <= fifo_cnt - FCW'(1);
            end
        end
    end

    // Output beat position within the line; resyncs on every last beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (pop) begin
            if (ds_wr_last || beat_at_end) begin
                beat_cnt <= '0;
            end else begin
                beat_cnt <= beat_cnt + BCW'(1);
            end
        end
    end

    // Tracker pointers and outstanding line count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trk_wr          <= '0;
            trk_rd          <= '0;
            outstanding_cnt <= '0;
        end else begin
            if (line_done) begin
                trk_wr <= trk_wr + TPW'(1);
            end
            if (trk_pop) begin
                trk_rd <= trk_rd + TPW'(1);
            end
            if (line_done && !trk_pop) begin
                outstanding_cnt <= outstanding_cnt + OCW'(1);
            end else if (!line_done && trk_pop) begin
                outstanding_cnt <= outstanding_cnt - OCW'(1);
            end
        end
    end

    // Release, completion and error reporting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evdb_entry_release     <= 1'b0;
            evdb_entry_release_idx <= '0;
            wb_done_vld            <= 1'b0;
            wb_done_rob_entry_id   <= '0;
            wb_done_err            <= 1'b0;
            proto_err              <= 1'b0;
        end else begin
            evdb_entry_release <= line_done;
            if (line_done) begin
                evdb_entry_release_idx <= idx_mem[rd_ptr];
            end
            wb_done_vld <= trk_pop;
            if (trk_pop) begin
                wb_done_rob_entry_id <= trk_mem[trk_rd];
                wb_done_err          <= ds_bresp_err;
            end
            if (beat_err || bresp_unexp) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule
